// File: rtl/or_request_splitter_if.sv
// Request/report bundle between the request sources, the splitter and its consumer.
// Valid/Ready: an Index transfers on a rising Clk edge where Valid and Ready are both 1; Valid/Index hold until then.
interface or_request_splitter_if #(
   parameter int N    = 8,
   parameter int IDXW = 3
);
   logic [N-1:0]    Req;
   logic            Ready;
   logic            Clear;
   logic            Valid;
   logic [IDXW-1:0] Index;
   logic            Any;
   logic            Overrun;

   modport master (
      output Req, Ready, Clear,
      input  Valid, Index, Any, Overrun
   );

   modport slave (
      input  Req, Ready, Clear,
      output Valid, Index, Any, Overrun
   );
endinterface

// File: rtl/or_request_splitter.sv
// Latches N request lines into a pending mask and reports pending sources one index at a time,
// lowest index first, while also exposing the merged OR flag and a sticky overrun flag.
module or_request_splitter #(
   parameter int N    = 8,
   parameter int IDXW = 3
) (
   input  logic                  Clk,
   input  logic                  Reset,
   or_request_splitter_if.slave  bus,
   output logic                  dbg_state
);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_PRESENT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    pending_q, pending_d;
   logic [IDXW-1:0] index_q, index_d;
   logic            any_q, any_d;
   logic            overrun_q, overrun_d;
   logic [N-1:0]    ack_mask;
   logic            accept;

   function automatic logic [IDXW-1:0] lowest_set(input logic [N-1:0] v);
      lowest_set = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = IDXW'(i);
      end
   endfunction

   always_comb begin
      accept   = (state_q == S_PRESENT) && bus.Ready;
      ack_mask = '0;
      for (int i = 0; i < N; i++) begin
         ack_mask[i] = accept && (index_q == IDXW'(i));
      end

      // New requests win over the acknowledge of the same bit.
      pending_d = (pending_q & ~ack_mask) | bus.Req;
      any_d     = |pending_d;

      overrun_d = overrun_q;
      if (bus.Clear) overrun_d = 1'b0;
      if (|(bus.Req & pending_q & ~ack_mask)) overrun_d = 1'b1;

      state_d = state_q;
      index_d = index_q;
      case (state_q)
         S_IDLE: begin
            if (|pending_q) begin
               index_d = lowest_set(pending_q);
               state_d = S_PRESENT;
            end
         end
         S_PRESENT: begin
            // Index is frozen until the consumer takes it, even if a lower bit arrives.
            if (bus.Ready) begin
               if (|pending_d) index_d = lowest_set(pending_d);
               else            state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         index_q   <= '0;
         any_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         index_q   <= index_d;
         any_q     <= any_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.Valid   = (state_q == S_PRESENT);
   assign bus.Index   = index_q;
   assign bus.Any     = any_q;
   assign bus.Overrun = overrun_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_or_request_splitter.sv
// Directed bench for or_request_splitter: reset, drain order, stall, set-wins, overrun/clear, mid-handshake reset.
module tb_or_request_splitter;

   localparam int N    = 8;
   localparam int IDXW = 3;

   logic clk;
   logic rst_n;
   logic dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [IDXW-1:0] exp_q[$];

   or_request_splitter_if #(.N(N), .IDXW(IDXW)) bus_if ();

   or_request_splitter #(.N(N), .IDXW(IDXW)) dut (
      .Clk       (clk),
      .Reset     (rst_n),
      .bus       (bus_if),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // one rising edge, then settle so outputs are sampled away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] req, input logic ready, input logic clear);
      bus_if.Req   = req;
      bus_if.Ready = ready;
      bus_if.Clear = clear;
   endtask

   task automatic check_outputs(input string tag, input logic valid, input logic [IDXW-1:0] idx,
                                input logic any, input logic ovr);
      check({tag, ".valid"},   32'(bus_if.Valid),   32'(valid));
      if (valid) check({tag, ".index"}, 32'(bus_if.Index), 32'(idx));
      check({tag, ".any"},     32'(bus_if.Any),     32'(any));
      check({tag, ".overrun"}, 32'(bus_if.Overrun), 32'(ovr));
   endtask

   initial begin
      rst_n = 1'b0;
      drive(8'hFF, 1'b0, 1'b0);

      // Reset holds everything at zero even with all requests asserted
      tick();
      tick();
      check_outputs("rst", 1'b0, '0, 1'b0, 1'b0);
      check("rst.index", 32'(bus_if.Index), 32'd0);
      check("rst.state", 32'(dbg_state), 32'd0);

      rst_n = 1'b1;
      tick();
      check_outputs("rel1", 1'b0, '0, 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      tick();
      check_outputs("rel2", 1'b1, 3'd0, 1'b1, 1'b0);
      check("rel2.state", 32'(dbg_state), 32'd1);

      // Drain all eight, one per cycle, ascending
      bus_if.Ready = 1'b1;
      for (int i = 1; i < N; i++) begin
         tick();
         check_outputs($sformatf("drain%0d", i), 1'b1, IDXW'(i), 1'b1, 1'b0);
      end
      tick();
      check_outputs("drain_end", 1'b0, '0, 1'b0, 1'b0);

      // Sparse pattern with Ready held high: 2,5,7
      drive(8'b1010_0100, 1'b1, 1'b0);
      tick();
      check_outputs("sp_lat", 1'b0, '0, 1'b1, 1'b0);
      bus_if.Req = 8'h00;
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd5);
      exp_q.push_back(3'd7);
      while (exp_q.size() > 0) begin
         logic [IDXW-1:0] e;
         tick();
         e = exp_q.pop_front();
         check_outputs($sformatf("sp_idx%0d", e), 1'b1, e, 1'b1, 1'b0);
      end
      tick();
      check_outputs("sp_end", 1'b0, '0, 1'b0, 1'b0);

      // Stall: index 6 held while a lower bit arrives
      drive(8'h40, 1'b0, 1'b0);
      tick();
      bus_if.Req = 8'h00;
      tick();
      check_outputs("st0", 1'b1, 3'd6, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin
         tick();
         check_outputs($sformatf("st%0d", i), 1'b1, 3'd6, 1'b1, 1'b0);
      end
      bus_if.Req = 8'h02;
      tick();
      check_outputs("st_low", 1'b1, 3'd6, 1'b1, 1'b0);
      bus_if.Req = 8'h00;
      tick();
      check_outputs("st_hold", 1'b1, 3'd6, 1'b1, 1'b0);
      bus_if.Ready = 1'b1;
      tick();
      check_outputs("st_acc6", 1'b1, 3'd1, 1'b1, 1'b0);
      tick();
      check_outputs("st_acc1", 1'b0, '0, 1'b0, 1'b0);
      bus_if.Ready = 1'b0;

      // Set wins over acknowledge of the same bit; no overrun
      drive(8'h08, 1'b0, 1'b0);
      tick();
      bus_if.Req = 8'h00;
      tick();
      check_outputs("sw_pres", 1'b1, 3'd3, 1'b1, 1'b0);
      drive(8'h08, 1'b1, 1'b0);
      tick();
      check_outputs("sw_again", 1'b1, 3'd3, 1'b1, 1'b0);
      bus_if.Req = 8'h00;
      tick();
      check_outputs("sw_done", 1'b0, '0, 1'b0, 1'b0);
      bus_if.Ready = 1'b0;

      // Overrun: collision sets, clear clears, set beats clear, holds otherwise
      drive(8'h10, 1'b0, 1'b0);
      tick();
      check_outputs("ov_first", 1'b0, '0, 1'b1, 1'b0);
      tick();
      check_outputs("ov_pres", 1'b1, 3'd4, 1'b1, 1'b1);
      bus_if.Req = 8'h00;
      tick();
      check("ov_hold", 32'(bus_if.Overrun), 32'd1);
      bus_if.Clear = 1'b1;
      tick();
      check("ov_clear", 32'(bus_if.Overrun), 32'd0);
      bus_if.Req = 8'h10;
      tick();
      check("ov_set_wins", 32'(bus_if.Overrun), 32'd1);
      drive(8'h00, 1'b0, 1'b0);
      tick();
      check("ov_hold2", 32'(bus_if.Overrun), 32'd1);
      bus_if.Clear = 1'b1;
      tick();
      check("ov_clear2", 32'(bus_if.Overrun), 32'd0);
      drive(8'h00, 1'b1, 1'b0);
      tick();
      check_outputs("ov_drain", 1'b0, '0, 1'b0, 1'b0);
      bus_if.Ready = 1'b0;

      // Reset mid-handshake: Valid=1, Index=5, pending F0
      bus_if.Req = 8'h20;
      tick();
      bus_if.Req = 8'h00;
      tick();
      check_outputs("mr_pres", 1'b1, 3'd5, 1'b1, 1'b0);
      bus_if.Req = 8'hD0;
      tick();
      check_outputs("mr_full", 1'b1, 3'd5, 1'b1, 1'b0);
      drive(8'h00, 1'b1, 1'b0);
      rst_n = 1'b0;
      tick();
      check_outputs("mr_rst", 1'b0, '0, 1'b0, 1'b0);
      check("mr_rst.index", 32'(bus_if.Index), 32'd0);
      rst_n = 1'b1;
      tick();
      check_outputs("mr_after", 1'b0, '0, 1'b0, 1'b0);
      check("mr_after.index", 32'(bus_if.Index), 32'd0);
      check("mr_after.state", 32'(dbg_state), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/or_request_splitter.md
Name: or_request_splitter

Overview:
- Converse of the OR combiner: accepts N independent request lines that would otherwise be OR-merged into a single flag.
- Latches every request into a pending mask and reports the pending sources back out one at a time, as indices, over a valid/ready handshake.
- Provides the merged flag (Any) so downstream logic can still use the OR result, while a consumer can determine exactly which sources fired.
- Sits between the gate-level request sources and the control/sequencing logic.

Parameters:
- N, 8, number of request inputs (2..32)
- IDXW, 3, width of Index; must satisfy 2^IDXW >= N

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-low reset
- Req  input  N  request pulses/levels, sampled every Clk edge
- Ready  input  1  consumer accepts the current Index
- Clear  input  1  synchronous clear of the Overrun flag
- Valid  output  1  Index holds a pending source
- Index  output  IDXW  number of the source being reported
- Any  output  1  registered OR of the pending mask
- Overrun  output  1  sticky flag: an event was merged into an already-pending bit

Behaviour:
- Reset (Reset==0 at a Clk edge): Pending=0, Valid=0, Index=0, Any=0, Overrun=0, state=IDLE. Reset overrides all other inputs, including mid-handshake; any held Index is discarded.
- Pending update each edge: Pending_next = (Pending & ~AckMask) | Req.
  - AckMask is one-hot at Index when Valid&&Ready, otherwise 0.
  - Set wins: if Req[i] rises in the same cycle bit i is acknowledged, bit i stays pending.
- Any = |Pending_next, registered, so it updates on the same edge as Pending.
- Overrun: set when Req[i]=1 while Pending[i]=1 and bit i is not being acknowledged that cycle. Cleared by Clear=1. If set and clear coincide, set wins. Otherwise holds.
- State machine, 2 states:
  - IDLE: Valid=0. If Pending!=0 (registered value), load Index=lowest set bit, set Valid=1, go to PRESENT.
  - PRESENT: Valid=1. Index and Valid hold stable while Ready=0, even if a lower-numbered bit becomes pending.
  - PRESENT on Valid&&Ready: compute Pending_next. If nonzero, load its lowest set bit into Index, keep Valid=1, stay in PRESENT (back-to-back, one index per cycle). If zero, Valid=0, go to IDLE.
- Latency: Req[i] sampled at edge k → Pending[i] and Any set at edge k. From IDLE, Valid/Index appear at edge k+1.
- Priority: lowest index first at each selection point. There is no fairness guarantee beyond this.
- Ready while Valid=0 is ignored and has no side effects.
- Bits at or above N do not exist. Index is always < N.

Test Plan:
- Reset with Req=8'hFF held → all outputs 0. First edge after release sets Any=1. Next edge gives Valid=1, Index=0.
- Req=8'b1010_0100 for one cycle, Ready=1 constant → Index sequence 2,5,7 on consecutive cycles. Valid then drops, Any=0 on the edge of the last accept.
- Req bit 6 pulses, Ready=0 for 5 cycles, then bit 1 pulses → Index stays 6 with Valid=1 until Ready. After accept, Index=1.
- Bit 3 pending and being accepted while Req[3]=1 on the same cycle → bit 3 remains pending, Index=3 again next cycle, Overrun stays 0.
- Req[4] pulsed twice while unacknowledged → Overrun=1. Clear=1 with no new collision → Overrun=0. Simultaneous collision and Clear → Overrun=1.
- Reset asserted while Valid=1, Index=5, Pending=8'hF0 → next edge all outputs 0, no stale Index after release.
